// File: rtl/sprinkler_pkg.sv
// sprinkler_pkg: shared sequencer states, zone sizing and lowest-zone helper
package sprinkler_pkg;
  localparam int NUM_ZONES = 4;
  localparam int ZONE_W = 2;
  localparam int DEF_DUR_W = 8;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;
  function automatic logic [ZONE_W-1:0] lowest_zone(input logic [NUM_ZONES-1:0] m);
    lowest_zone = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--)
      if (m[i]) lowest_zone = ZONE_W'(i);
  endfunction
endpackage

// File: rtl/zone_demux.sv
// zone_demux: 2-to-4 decoder with enable driving one valve line
module zone_demux
  import sprinkler_pkg::*;
(
  input  logic [ZONE_W-1:0]    s,
  input  logic                 en,
  output logic [NUM_ZONES-1:0] y
);
  always_comb y = en ? NUM_ZONES'(1) << s : '0;
endmodule

// File: rtl/valve_zone_sequencer.sv
// valve_zone_sequencer: steps through masked zones, one valve open at a time
module valve_zone_sequencer
  import sprinkler_pkg::*;
#(
  parameter int DUR_W = DEF_DUR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic [DUR_W-1:0]     dur,
  output logic [NUM_ZONES-1:0] valve,
  output logic [ZONE_W-1:0]    zone,
  output logic                 busy,
  output logic                 done
);
  state_t state_q, state_d;
  logic [NUM_ZONES-1:0] mask_q, mask_d;
  logic [DUR_W-1:0] dur_q, dur_d, cnt_q, cnt_d;
  logic [ZONE_W-1:0] zone_q, zone_d;
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    dur_d = dur_q;
    cnt_d = cnt_q;
    zone_d = zone_q;
    case (state_q)
      IDLE: if (start) begin
        mask_d = zone_mask;
        dur_d = dur;
        zone_d = '0;
        state_d = (zone_mask == '0 || dur == '0) ? DONE : SEL;
      end
      SEL: if (stop) state_d = DONE;
      else if (|mask_q) begin
        zone_d = lowest_zone(mask_q);
        cnt_d = dur_q;
        state_d = RUN;
      end else state_d = DONE;
      RUN: if (stop) state_d = DONE;
      else if (tick) begin
        // guarded decrement keeps cnt from wrapping below zero
        cnt_d = (cnt_q != '0) ? cnt_q - DUR_W'(1) : cnt_q;
        if (cnt_q == DUR_W'(1)) begin
          mask_d[zone_q] = 1'b0;
          state_d = GAP;
        end
      end
      GAP: state_d = stop ? DONE : SEL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      dur_q <= '0;
      cnt_q <= '0;
      zone_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      dur_q <= dur_d;
      cnt_q <= cnt_d;
      zone_q <= zone_d;
    end
  end
  zone_demux u_demux (
    .s  (zone_q),
    .en (state_q == RUN),
    .y  (valve)
  );
  assign zone = zone_q;
  assign busy = state_q inside {SEL, RUN, GAP};
  assign done = state_q == DONE;
endmodule

// File: tb/tb_valve_zone_sequencer.sv
// tb_valve_zone_sequencer: per-cycle output expectations queued and checked after each edge
module tb_valve_zone_sequencer;
  typedef struct packed {
    logic [3:0] v;
    logic [1:0] z;
    logic       b;
    logic       d;
  } exp_t;
  logic clk = 1'b0;
  logic rst, tick, start, stop;
  logic [3:0] zone_mask;
  logic [7:0] dur;
  logic [3:0] valve;
  logic [1:0] zone;
  logic busy, done;
  int n_chk = 0;
  int n_fail = 0;
  string scen = "init";
  exp_t sb[$];
  always #5 clk = ~clk;
  valve_zone_sequencer #(.DUR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .zone_mask (zone_mask),
    .dur       (dur),
    .valve     (valve),
    .zone      (zone),
    .busy      (busy),
    .done      (done)
  );
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h at %0t", scen, tag, obs, exp, $time);
    end
  endtask
  task automatic push(input logic [3:0] v, input logic [1:0] z, input logic b, input logic d);
    sb.push_back({v, z, b, d});
  endtask
  task automatic step(input logic tk, input logic st, input logic sp);
    exp_t e;
    tick = tk;
    start = st;
    stop = sp;
    @(posedge clk);
    #1;
    tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s.underflow: got no expectation required one", scen);
    end else begin
      e = sb.pop_front();
      check("valve", {4'b0, valve}, {4'b0, e.v});
      check("zone", {6'b0, zone}, {6'b0, e.z});
      check("busy", {7'b0, busy}, {7'b0, e.b});
      check("done", {7'b0, done}, {7'b0, e.d});
    end
  endtask
  initial begin
    rst = 1'b1;
    tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    zone_mask = 4'b0;
    dur = 8'd0;
    scen = "reset";
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    scen = "rst_run";
    zone_mask = 4'b0010;
    dur = 8'd5;
    push(4'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    push(4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    push(4'b0010, 2'd1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    scen = "normal";
    zone_mask = 4'b1010;
    dur = 8'd3;
    push(4'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) push(4'b0010, 2'd1, 1'b1, 1'b0);
    repeat (2) push(4'b0, 2'd1, 1'b1, 1'b0);
    repeat (3) push(4'b1000, 2'd3, 1'b1, 1'b0);
    repeat (2) push(4'b0, 2'd3, 1'b1, 1'b0);
    push(4'b0, 2'd3, 1'b0, 1'b1);
    push(4'b0, 2'd3, 1'b0, 1'b0);
    repeat (12) step(1'b1, 1'b0, 1'b0);
    scen = "sparse";
    zone_mask = 4'b0001;
    dur = 8'd2;
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || i == 11 || i == 12) push(4'b0, 2'd0, 1'b1, 1'b0);
      else if (i <= 10) push(4'b0001, 2'd0, 1'b1, 1'b0);
      else if (i == 13) push(4'b0, 2'd0, 1'b0, 1'b1);
      else push(4'b0, 2'd0, 1'b0, 1'b0);
      step(i % 5 == 1, i == 0, 1'b0);
    end
    scen = "stop";
    zone_mask = 4'b1111;
    dur = 8'd10;
    for (int i = 0; i < 36; i++) begin
      if (i == 0 || i == 11 || i == 12) push(4'b0, 2'd0, 1'b1, 1'b0);
      else if (i <= 10) push(4'b0001, 2'd0, 1'b1, 1'b0);
      else if (i <= 22) push(4'b0010, 2'd1, 1'b1, 1'b0);
      else if (i <= 24) push(4'b0, 2'd1, 1'b1, 1'b0);
      else if (i <= 26) push(4'b0100, 2'd2, 1'b1, 1'b0);
      else if (i == 27) push(4'b0, 2'd2, 1'b0, 1'b1);
      else push(4'b0, 2'd2, 1'b0, 1'b0);
      step(1'b1, i == 0, i == 27);
    end
    scen = "empty_mask";
    zone_mask = 4'b0000;
    dur = 8'd5;
    push(4'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    scen = "empty_dur";
    zone_mask = 4'b0001;
    dur = 8'd0;
    push(4'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    scen = "ign_start";
    zone_mask = 4'b0100;
    dur = 8'd2;
    push(4'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    push(4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    zone_mask = 4'b0001;
    dur = 8'd5;
    push(4'b0100, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    push(4'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push(4'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    push(4'b0, 2'd2, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    push(4'b0, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    scen = "idle_stop";
    push(4'b0, 2'd2, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    scen = "start_stop";
    zone_mask = 4'b0001;
    dur = 8'd1;
    push(4'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    push(4'b0001, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push(4'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push(4'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    push(4'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    push(4'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    scen = "end";
    check("sb_left", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
